shared_buffer_arbiter: RTL and testbench

Arbitrates the single-port 512-bit shared buffer between NREQ requesters: weight loader, activation loader, output writeback and DMA. Each requester has a valid/ready port. Requests are granted round-robin, at most one access per cycle. Read data returns one cycle later with a per-requester valid strobe. An idle power manager drops the buffer into retention (RETN low) after a programmable idle period and sequences wake-up before the next grant.

---
 rtl/shared_buffer_arbiter_pkg.sv | 21 ++
 rtl/shared_buffer_arbiter_if.sv | 26 ++
 rtl/shared_buffer_arbiter_rr.sv | 51 +++++
 rtl/shared_buffer_arbiter.sv | 137 +++++++++++++
 tb/tb_shared_buffer_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_buffer_arbiter_pkg.sv
// Shared types and sizing helpers for the shared buffer arbiter.
package sb_arb_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } pm_state_e;

    localparam int DEF_AW = 13;
    localparam int DEF_DW = 512;

    function automatic int idle_cnt_w(input int idle_limit);
        return $clog2(idle_limit + 1);
    endfunction

    function automatic int wake_cnt_w(input int wake_cycles);
        return $clog2(wake_cycles + 1);
    endfunction

endpackage

// File: rtl/shared_buffer_arbiter_if.sv
// Requester-side bus of the shared buffer arbiter: request handshake and read response.
interface shared_buffer_arbiter_if
    import sb_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/shared_buffer_arbiter_rr.sv
// Round-robin arbiter: scan starts one past the last granted requester.
module rr_arbiter #(
    parameter int  NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] last_grant_reg;
    logic [IW:0]   cand [NREQ];
    logic          hit;

    // cand[k] is the requester examined at scan position k, wrapped modulo NREQ
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum      = {1'b0, last_grant_reg} + (IW+1)'(gi + 1);
            assign cand[gi] = (sum >= (IW+1)'(NREQ)) ? sum - (IW+1)'(NREQ) : sum;
        end
    endgenerate

    always_comb begin
        hit       = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit && req[cand[k][IW-1:0]]) begin
                hit       = 1'b1;
                grant_idx = cand[k][IW-1:0];
            end
        end
        if (en && hit) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            last_grant_reg <= IW'(NREQ - 1);
        end else if (en && hit) begin
            last_grant_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/shared_buffer_arbiter.sv
// Arbitrates a single-port shared buffer between NREQ requesters and manages
// its retention power state (ACTIVE / SLEEP / WAKE).
module shared_buffer_arbiter
    import sb_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int IDLE_LIMIT  = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     sleep_en,
    shared_buffer_arbiter_if.slave   bus,
    output logic                     sb_CEN,
    output logic                     sb_WEN,
    output logic [AW-1:0]            sb_A,
    output logic [DW-1:0]            sb_D,
    output logic                     sb_RETN,
    input  logic [DW-1:0]            sb_Q,
    output logic                     busy
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ICW = idle_cnt_w(IDLE_LIMIT);
    localparam int WCW = wake_cnt_w(WAKE_CYCLES);

    pm_state_e       state_reg, state_next;
    logic [ICW-1:0]  idle_cnt_reg, idle_cnt_next;
    logic [WCW-1:0]  wake_cnt_reg, wake_cnt_next;
    logic            pending_reg;
    logic [IW-1:0]   rsp_id_reg;
    logic            retn_reg;

    logic            any_valid;
    logic            arb_en;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            granted;
    logic            grant_we;

    assign any_valid = |bus.req_valid;
    assign arb_en    = (state_reg == ST_ACTIVE);
    assign granted   = |grant;
    assign grant_we  = bus.req_we[grant_idx];

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req       (bus.req_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= ST_ACTIVE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sleep is refused while a request or a read response is outstanding.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACTIVE: if (sleep_en && idle_cnt_reg == ICW'(IDLE_LIMIT) && !any_valid && !pending_reg)
                           state_next = ST_SLEEP;
            ST_SLEEP:  if (any_valid || !sleep_en)
                           state_next = ST_WAKE;
            ST_WAKE:   if (wake_cnt_reg == WCW'(WAKE_CYCLES - 1))
                           state_next = ST_ACTIVE;
            default:   state_next = ST_ACTIVE;
        endcase
    end

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (state_next != state_reg || any_valid) begin
            idle_cnt_next = '0;
        end else if (state_reg == ST_ACTIVE && !pending_reg && idle_cnt_reg != ICW'(IDLE_LIMIT)) begin
            idle_cnt_next = idle_cnt_reg + ICW'(1);
        end

        wake_cnt_next = wake_cnt_reg;
        if (state_next != state_reg) begin
            wake_cnt_next = '0;
        end else if (state_reg == ST_WAKE) begin
            wake_cnt_next = wake_cnt_reg + WCW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            idle_cnt_reg <= '0;
            wake_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            rsp_id_reg   <= '0;
            retn_reg     <= 1'b1;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            wake_cnt_reg <= wake_cnt_next;
            pending_reg  <= granted && !grant_we;
            if (granted) begin
                rsp_id_reg <= grant_idx;
            end
            retn_reg <= (state_next != ST_SLEEP);
        end
    end

    always_comb begin
        sb_CEN = 1'b1;
        sb_WEN = 1'b1;
        sb_A   = '0;
        sb_D   = '0;
        if (granted) begin
            sb_CEN = 1'b0;
            sb_A   = bus.req_addr[grant_idx*AW +: AW];
            if (grant_we) begin
                sb_WEN = 1'b0;
                sb_D   = bus.req_wdata[grant_idx*DW +: DW];
            end
        end

        bus.req_ready = grant;
        bus.rsp_valid = '0;
        bus.rsp_valid[rsp_id_reg] = pending_reg;
        bus.rsp_rdata = pending_reg ? sb_Q : '0;

        busy = (state_reg != ST_SLEEP) && (any_valid || pending_reg || state_reg == ST_WAKE);
    end

    assign sb_RETN = retn_reg;

endmodule

// File: tb/tb_shared_buffer_arbiter.sv
// Randomised and directed bench for shared_buffer_arbiter with a reference model and response scoreboard.
module tb_shared_buffer_arbiter;
    import sb_arb_pkg::*;

    localparam int NREQ        = 4;
    localparam int AW          = DEF_AW;
    localparam int DW          = DEF_DW;
    localparam int IDLE_LIMIT  = 64;
    localparam int WAKE_CYCLES = 2;
    localparam int DEPTH       = 1 << AW;
    localparam int M_ACTIVE = 0, M_SLEEP = 1, M_WAKE = 2;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          sleep_en = 1'b0;
    logic          sb_CEN, sb_WEN, sb_RETN, busy;
    logic [AW-1:0] sb_A;
    logic [DW-1:0] sb_D;
    logic [DW-1:0] sb_Q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    shared_buffer_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    shared_buffer_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .IDLE_LIMIT(IDLE_LIMIT), .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .sleep_en (sleep_en),
        .bus      (bus.slave),
        .sb_CEN   (sb_CEN),
        .sb_WEN   (sb_WEN),
        .sb_A     (sb_A),
        .sb_D     (sb_D),
        .sb_RETN  (sb_RETN),
        .sb_Q     (sb_Q),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_pat(input int a);
        logic [31:0] w;
        if (a == 5) return {64{8'hA5}};
        w = 32'(a) * 32'h9E37_79B9 + 32'h1357;
        return {16{w}};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
        return d;
    endfunction

    // Buffer macro: registered read, write-through nothing.
    logic [DW-1:0] env_mem [0:DEPTH-1];
    bit            env_wr  [0:DEPTH-1];
    always @(posedge CLK) begin
        if (!sb_CEN) begin
            if (!sb_WEN) begin
                env_mem[sb_A] <= sb_D;
                env_wr[sb_A]  <= 1'b1;
            end else begin
                sb_Q <= env_wr[sb_A] ? env_mem[sb_A] : init_pat(int'(sb_A));
            end
        end
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: power state, round-robin pointer and buffer contents.
    int            m_state = M_ACTIVE;
    int            m_idle = 0, m_wake = 0, m_last = NREQ - 1;
    bit            m_pend = 0;
    logic [DW-1:0] m_mem [0:DEPTH-1];
    bit            m_wr  [0:DEPTH-1];

    always @(negedge CLK) begin : ref_model
        int            g, a, idx;
        logic [NREQ-1:0] eg;
        bit            anyv, rd;
        exp_t          e;
        if (!RSTN) begin
            m_state = M_ACTIVE; m_idle = 0; m_wake = 0; m_last = NREQ - 1; m_pend = 0;
            exp_q.delete();
            check("rst_req_ready", bus.req_ready, '0);
            check("rst_rsp_valid", bus.rsp_valid, '0);
            check("rst_sb_CEN", sb_CEN, 1);
            check("rst_sb_WEN", sb_WEN, 1);
            check("rst_sb_RETN", sb_RETN, 1);
        end else begin
            anyv = |bus.req_valid;
            g = -1;
            if (m_state == M_ACTIVE) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            check("req_ready", bus.req_ready, eg);
            check("sb_RETN", sb_RETN, m_state != M_SLEEP);
            check("busy", busy, (m_state != M_SLEEP) && (anyv || m_pend || m_state == M_WAKE));
            rd = 0;
            if (g >= 0) begin
                a = int'(bus.req_addr[g*AW +: AW]);
                check("sb_CEN", sb_CEN, 0);
                check("sb_A", sb_A, a);
                if (bus.req_we[g]) begin
                    check("sb_WEN_wr", sb_WEN, 0);
                    check("sb_D_wr", sb_D, bus.req_wdata[g*DW +: DW]);
                    m_mem[a] = bus.req_wdata[g*DW +: DW];
                    m_wr[a]  = 1;
                end else begin
                    check("sb_WEN_rd", sb_WEN, 1);
                    check("sb_D_rd", sb_D, '0);
                    e.id = g;
                    e.data = m_wr[a] ? m_mem[a] : init_pat(a);
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    rd = 1;
                end
                m_last = g;
            end else begin
                check("sb_CEN_idle", sb_CEN, 1);
                check("sb_WEN_idle", sb_WEN, 1);
                check("sb_A_idle", sb_A, '0);
                check("sb_D_idle", sb_D, '0);
            end
            case (m_state)
                M_ACTIVE: begin
                    if (sleep_en && m_idle == IDLE_LIMIT && !anyv && !m_pend) begin
                        m_state = M_SLEEP; m_idle = 0;
                    end else if (anyv) m_idle = 0;
                    else if (!m_pend && m_idle < IDLE_LIMIT) m_idle++;
                end
                M_SLEEP: if (anyv || !sleep_en) begin m_state = M_WAKE; m_wake = 0; end
                default: begin
                    m_wake++;
                    if (m_wake == WAKE_CYCLES) begin m_state = M_ACTIVE; m_idle = 0; end
                end
            endcase
            m_pend = rd;
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT strobes rsp_valid.
    always @(negedge CLK) begin : monitor
        exp_t            e;
        logic [NREQ-1:0] ev;
        if (RSTN) begin
            if (bus.rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b, expected none (cycle %0d)", bus.rsp_valid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    ev = '0;
                    ev[e.id] = 1'b1;
                    check("rsp_valid", bus.rsp_valid, ev);
                    check("rsp_rdata", bus.rsp_rdata, e.data);
                    check("rsp_latency", cyc, e.cyc + 1);
                    $display("rsp req=%0d cycle=%0d data=%0h", e.id, cyc, bus.rsp_rdata);
                end
            end else begin
                check("rsp_rdata_idle", bus.rsp_rdata, '0);
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL rsp_missing: got no rsp_valid, expected req %0d (cycle %0d)", exp_q[0].id, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(output logic [NREQ-1:0] hs);
        @(negedge CLK);
        hs = bus.req_valid & bus.req_ready;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input int i, input bit we, input int addr, input logic [DW-1:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = AW'(addr);
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_hs(input int i, input int maxc);
        logic [NREQ-1:0] hs;
        bit done;
        done = 0;
        for (int n = 0; n < maxc && !done; n++) begin
            tick(hs);
            if (hs[i]) done = 1;
        end
        bus.req_valid[i] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL handshake_timeout: requester %0d got no grant, required within %0d cycles", i, maxc);
        end
    endtask

    task automatic clear_all();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    initial begin
        repeat (20000) @(posedge CLK);
        $display("FAIL watchdog: bench did not finish, required under 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] hs;
        int lat;
        bit quiet;
        clear_all();
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;

        // Single read from requester 2.
        tick(hs);
        issue(2, 0, 5, '0);
        wait_hs(2, 1);
        tick(hs);

        // Write by requester 1 followed immediately by a read from requester 3.
        issue(1, 1, 7, DW'(32'h1234));
        wait_hs(1, 1);
        issue(3, 0, 7, '0);
        wait_hs(3, 1);
        repeat (2) tick(hs);

        // Round robin with all requesters valid straight out of reset.
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < NREQ; i++) issue(i, 0, $urandom_range(0, 15), '0);
        for (int n = 0; n < 12; n++) begin
            tick(hs);
            check("rr_order", hs, NREQ'(1) << (n % NREQ));
            for (int i = 0; i < NREQ; i++)
                if (hs[i]) issue(i, 0, $urandom_range(0, 15), '0);
        end
        clear_all();
        repeat (2) tick(hs);

        // Random traffic with quiet windows long enough to reach sleep.
        for (int n = 0; n < 450; n++) begin
            quiet = (n % 150) >= 70;
            sleep_en = ((n / 40) % 4) != 3;
            tick(hs);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && !quiet && $urandom_range(0, 3) == 0)
                    issue(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), rand_data());
            end
        end
        clear_all();

        // Sleep entry and wake latency.
        sleep_en = 1'b1;
        repeat (70) tick(hs);
        check("retn_in_sleep", sb_RETN, 0);
        issue(0, 0, 3, '0);
        lat = -1;
        for (int n = 0; n < 10 && lat < 0; n++) begin
            @(negedge CLK);
            if (bus.req_ready[0]) lat = n;
            @(posedge CLK);
            #1;
            if (n == 0) check("retn_after_req", sb_RETN, 1);
        end
        bus.req_valid[0] = 1'b0;
        check("wake_latency", lat, WAKE_CYCLES + 1);
        sleep_en = 1'b0;
        repeat (2) tick(hs);

        // Reset in the cycle after a read grant.
        issue(1, 0, 9, '0);
        wait_hs(1, 4);
        #1 RSTN = 1'b0;
        #1;
        check("rst_mid_rsp_valid", bus.rsp_valid, '0);
        check("rst_mid_retn", sb_RETN, 1);
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < NREQ; i++) issue(i, 0, i, '0);
        tick(hs);
        check("first_after_reset", hs, NREQ'(1));
        for (int n = 0; n < NREQ - 1; n++) begin
            for (int i = 0; i < NREQ; i++) if (hs[i]) bus.req_valid[i] = 1'b0;
            tick(hs);
        end
        clear_all();

        // Sleep gating by sleep_en, and wake on sleep_en falling.
        sleep_en = 1'b0;
        repeat (200) tick(hs);
        check("retn_gated", sb_RETN, 1);
        sleep_en = 1'b1;
        repeat (70) tick(hs);
        check("retn_sleep2", sb_RETN, 0);
        check("busy_sleep", busy, 0);
        sleep_en = 1'b0;
        tick(hs);
        check("retn_wake_en", sb_RETN, 1);
        check("busy_wake1", busy, 1);
        tick(hs);
        check("busy_wake2", busy, 1);
        tick(hs);
        check("busy_active", busy, 0);

        repeat (3) tick(hs);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
